// File: rtl/dpram.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
// Contents are not reset; rd_data holds its value whenever rd_en is low.
module dpram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store the word at wr_addr when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered output, updated only on a read so it can act as a holding stage.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO controller. The dpram registered read
// port is the output stage, so the head word sits in rd_data while out_valid is high.
module sync_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = (2 ** ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AFULL_L = AFULL_THRESH[ADDR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  push;
    logic                  pop;
    logic                  rd_issue;

    // Status flags depend only on the level register, never on this cycle's handshakes.
    assign in_ready    = (level != DEPTH_L);
    assign almost_full = (level >= AFULL_L);

    // Handshakes; nothing is accepted while reset is asserted. A read is issued whenever
    // the RAM holds unread words and the output stage is empty or being emptied this edge.
    assign push     = in_valid & in_ready & ~rst;
    assign pop      = out_valid & out_ready & ~rst;
    assign rd_issue = (ram_cnt != '0) & (~out_valid | out_ready) & ~rst;

    dpram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (push),
        .wr_addr(wr_ptr),
        .wr_data(in_data),
        .rd_en  (rd_issue),
        .rd_addr(rd_ptr),
        .rd_data(out_data)
    );

    // Pointer, occupancy and output-valid bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            level     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt <= ram_cnt + push - rd_issue;
            level   <= level + push - pop;
            if (rd_issue) begin
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
